ex_iter: RTL and testbench



---
 rtl/ex_iter.sv | 171 +++++++++++++++++
 tb/tb_ex_iter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_iter.sv
// Execute stage: single-cycle logic ops, iterative one-bit-per-cycle shifts.
// Define EX_BARREL_SHIFT_EN to replace the iterative shifter with a combinational barrel shifter.
module ex_iter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  output logic              valid_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stallreq_o
);

  localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_r;
  logic [SHAMT_W-1:0]  cnt_r;
  logic [DATA_W-1:0]   work_r;
  logic [7:0]          op_r;
  logic [4:0]          wd_r;
  logic                wreg_r;

  logic [DATA_W-1:0]   res_s;
  logic                wr_s;
  logic                iter_s;
  logic [DATA_W-1:0]   step_s;
  logic [SHAMT_W-1:0]  kamt_s;

  function automatic logic [DATA_W-1:0] shift_step(input logic [7:0] op,
                                                   input logic [DATA_W-1:0] w);
    case (op)
      EXE_SLL_OP: return {w[DATA_W-2:0], 1'b0};
      EXE_SRL_OP: return {1'b0, w[DATA_W-1:1]};
      EXE_SRA_OP: return {w[DATA_W-1], w[DATA_W-1:1]};
      default:    return w;
    endcase
  endfunction

`ifdef EX_BARREL_SHIFT_EN
  function automatic logic [DATA_W-1:0] barrel(input logic [7:0] op,
                                               input logic [DATA_W-1:0] w,
                                               input logic [SHAMT_W-1:0] k);
    case (op)
      EXE_SLL_OP: return w << k;
      EXE_SRL_OP: return w >> k;
      EXE_SRA_OP: return DATA_W'($signed(w) >>> k);
      default:    return {DATA_W{1'b0}};
    endcase
  endfunction

  assign stallreq_o = 1'b0;
`else
  assign stallreq_o = (state_r == SHIFT);
`endif

  assign ready_o = (state_r == IDLE);
  assign kamt_s  = reg1_i[SHAMT_W-1:0];
  assign step_s  = shift_step(op_r, work_r);

  // Decode the incoming bundle into a single-cycle result or an iterative start
  always_comb begin
    res_s  = {DATA_W{1'b0}};
    wr_s   = wreg_i;
    iter_s = 1'b0;
    case (alusel_i)
      EXE_RES_LOGIC: begin
        case (aluop_i)
          EXE_AND_OP: res_s = reg1_i & reg2_i;
          EXE_OR_OP:  res_s = reg1_i | reg2_i;
          EXE_XOR_OP: res_s = reg1_i ^ reg2_i;
          EXE_NOR_OP: res_s = ~(reg1_i | reg2_i);
          default:    wr_s  = 1'b0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (aluop_i)
          EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP: begin
`ifdef EX_BARREL_SHIFT_EN
            res_s = barrel(aluop_i, reg2_i, kamt_s);
`else
            if (kamt_s == {SHAMT_W{1'b0}}) begin
              res_s = reg2_i;
            end else begin
              iter_s = 1'b1;
            end
`endif
          end
          default: wr_s = 1'b0;
        endcase
      end
      EXE_RES_NOP: res_s = {DATA_W{1'b0}};
      default:     wr_s  = 1'b0;
    endcase
  end

  // Control FSM, shift datapath and registered writeback bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {SHAMT_W{1'b0}};
      work_r  <= {DATA_W{1'b0}};
      op_r    <= 8'h00;
      wd_r    <= 5'd0;
      wreg_r  <= 1'b0;
      valid_o <= 1'b0;
      wd_o    <= 5'd0;
      wreg_o  <= 1'b0;
      wdata_o <= {DATA_W{1'b0}};
    end else begin
      valid_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (valid_i) begin
            if (iter_s) begin
              work_r  <= reg2_i;
              cnt_r   <= kamt_s;
              op_r    <= aluop_i;
              wd_r    <= wd_i;
              wreg_r  <= wreg_i;
              state_r <= SHIFT;
            end else begin
              valid_o <= 1'b1;
              wd_o    <= wd_i;
              wreg_o  <= wr_s;
              wdata_o <= res_s;
            end
          end
        end
        SHIFT: begin
          work_r <= step_s;
          cnt_r  <= cnt_r - {{(SHAMT_W-1){1'b0}}, 1'b1};
          // Last step: the freshly shifted value is the result
          if (cnt_r == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
            valid_o <= 1'b1;
            wd_o    <= wd_r;
            wreg_o  <= wreg_r;
            wdata_o <= step_s;
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_iter.sv
// Self-checking bench for ex_iter: directed scenarios plus random ops against an arithmetic reference model.
module tb_ex_iter;

  localparam logic [7:0] AND_OP = 8'b0010_0100;
  localparam logic [7:0] OR_OP  = 8'b0010_0101;
  localparam logic [7:0] XOR_OP = 8'b0010_0110;
  localparam logic [7:0] NOR_OP = 8'b0010_0111;
  localparam logic [7:0] SLL_OP = 8'b0111_1100;
  localparam logic [7:0] SRL_OP = 8'b0000_0010;
  localparam logic [7:0] SRA_OP = 8'b0000_0011;
  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
`ifdef EX_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [7:0]  aluop_i = 8'h00;
  logic [2:0]  alusel_i = 3'b000;
  logic [31:0] reg1_i = 32'h0;
  logic [31:0] reg2_i = 32'h0;
  logic [4:0]  wd_i = 5'd0;
  logic        wreg_i = 1'b0;
  logic        valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;

  int total = 0;
  int bad = 0;

  ex_iter dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .aluop_i(aluop_i), .alusel_i(alusel_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .valid_o(valid_o), .wd_o(wd_o),
    .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: result, write enable and number of edges after accept until valid_o
  task automatic model(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2, input logic wr,
                       output logic [31:0] er, output logic ew, output int n);
    int k;
    k  = int'(r1 % 32);
    er = 32'h0;
    ew = 1'b0;
    n  = 0;
    if (sel == RES_LOGIC && op == AND_OP)      begin er = r2 & r1;    ew = wr; end
    else if (sel == RES_LOGIC && op == OR_OP)  begin er = r1 | r2;    ew = wr; end
    else if (sel == RES_LOGIC && op == XOR_OP) begin er = r1 ^ r2;    ew = wr; end
    else if (sel == RES_LOGIC && op == NOR_OP) begin er = ~(r1 | r2); ew = wr; end
    else if (sel == RES_SHIFT && op == SLL_OP) begin er = r2 << k; ew = wr; n = BARREL ? 0 : k; end
    else if (sel == RES_SHIFT && op == SRL_OP) begin er = r2 >> k; ew = wr; n = BARREL ? 0 : k; end
    else if (sel == RES_SHIFT && op == SRA_OP) begin er = 32'($signed(r2) >>> k); ew = wr; n = BARREL ? 0 : k; end
    else if (sel == RES_NOP)                   begin er = 32'h0; ew = wr; end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wd, input logic wr);
    aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2; wd_i = wd; wreg_i = wr;
    valid_i = 1'b1;
  endtask

  // Issue one bundle from idle and follow it to its writeback cycle
  task automatic run_op(input string tag, input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [4:0] wd, input logic wr);
    logic [31:0] er; logic ew; int n;
    model(op, sel, r1, r2, wr, er, ew, n);
    drive(op, sel, r1, r2, wd, wr);
    chk({tag, "_ready_pre"}, {31'd0, ready_o}, 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c < n) begin
        chk({tag, "_busy_valid"}, {31'd0, valid_o}, 32'd0);
        chk({tag, "_busy_stall"}, {31'd0, stallreq_o}, 32'd1);
        chk({tag, "_busy_ready"}, {31'd0, ready_o}, 32'd0);
      end else begin
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        chk({tag, "_wdata"}, wdata_o, er);
        chk({tag, "_wd"}, {27'd0, wd_o}, {27'd0, wd});
        chk({tag, "_wreg"}, {31'd0, wreg_o}, {31'd0, ew});
        chk({tag, "_ready_post"}, {31'd0, ready_o}, 32'd1);
      end
    end
    @(posedge clk); #1;
    chk({tag, "_single_pulse"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    logic [7:0] ops [0:9];
    logic [2:0] sels [0:9];
    int sra_n;
    ops  = '{AND_OP, OR_OP, XOR_OP, NOR_OP, SLL_OP, SRL_OP, SRA_OP, 8'h00, 8'hFF, 8'hFF};
    sels = '{RES_LOGIC, RES_LOGIC, RES_LOGIC, RES_LOGIC, RES_SHIFT, RES_SHIFT, RES_SHIFT,
             RES_NOP, RES_LOGIC, RES_SHIFT};

    // Reset with a bundle presented
    rst = 1'b1;
    drive(OR_OP, RES_LOGIC, 32'hFFFF_FFFF, 32'h1, 5'd7, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_wd", {27'd0, wd_o}, 32'd0);
    chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    valid_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("or",  OR_OP,  RES_LOGIC, 32'h0000_FF00, 32'h00FF_00FF, 5'd3, 1'b1);
    chk("or_const", 32'h00FF_FFFF, 32'h0000_FF00 | 32'h00FF_00FF);
    run_op("nor", NOR_OP, RES_LOGIC, 32'h0000_FF00, 32'h00FF_00FF, 5'd4, 1'b1);
    run_op("sra4", SRA_OP, RES_SHIFT, 32'd4, 32'h8000_0010, 5'd5, 1'b1);
    run_op("srl4", SRL_OP, RES_SHIFT, 32'd4, 32'h8000_0010, 5'd6, 1'b1);
    run_op("sll0", SLL_OP, RES_SHIFT, 32'd0, 32'h0000_1234, 5'd8, 1'b1);
    run_op("unk",  8'hFF,  RES_LOGIC, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, 1'b1);
    run_op("nop",  8'h00,  RES_NOP,   32'h1111_1111, 32'h2222_2222, 5'd10, 1'b1);
    run_op("sra1", SRA_OP, RES_SHIFT, 32'd1, 32'h8000_0001, 5'd11, 1'b0);

    // An OR bundle held while a 31-step SLL is running must wait for it
    sra_n = BARREL ? 0 : 31;
    drive(SLL_OP, RES_SHIFT, 32'd31, 32'd1, 5'd12, 1'b1);
    @(posedge clk); #1;
    drive(OR_OP, RES_LOGIC, 32'h0000_00F0, 32'h0000_000F, 5'd13, 1'b1);
    for (int c = 0; c <= sra_n; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c < sra_n) begin
        chk("hold_novalid", {31'd0, valid_o}, 32'd0);
      end else begin
        chk("hold_sll_valid", {31'd0, valid_o}, 32'd1);
        chk("hold_sll_wdata", wdata_o, 32'h8000_0000);
        chk("hold_sll_wd", {27'd0, wd_o}, 32'd12);
        chk("hold_ready", {31'd0, ready_o}, 32'd1);
      end
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("hold_or_valid", {31'd0, valid_o}, 32'd1);
    chk("hold_or_wdata", wdata_o, 32'h0000_00FF);
    chk("hold_or_wd", {27'd0, wd_o}, 32'd13);
    @(posedge clk); #1;
    chk("hold_or_single", {31'd0, valid_o}, 32'd0);

    // Reset in the middle of an SLL by 20 abandons it
    drive(SLL_OP, RES_SHIFT, 32'd20, 32'h0000_0003, 5'd14, 1'b1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd1);
    chk("mid_rst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("mid_rst_wdata", wdata_o, 32'd0);
    for (int c = 0; c < 24; c++) begin
      chk("mid_rst_novalid", {31'd0, valid_o}, 32'd0);
      @(posedge clk); #1;
    end

    // Random bundles
    for (int i = 0; i < 40; i++) begin
      int idx;
      logic [31:0] r1;
      idx = $urandom_range(0, 9);
      r1  = $urandom;
      if (sels[idx] == RES_SHIFT) r1 = {r1[31:5], 5'(r1[4:0] % 12)};
      run_op("rnd", ops[idx], sels[idx], r1, $urandom, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
